serial_tx_framer: RTL and testbench

SERIAL_TX_FRAMER -- requirements
Module: serial_tx_framer

---
 rtl/serial_tx_framer_if.sv | 24 ++
 rtl/serial_tx_framer.sv | 125 ++++++++++++
 tb/tb_serial_tx_framer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_framer_if.sv
// Bus-side signals of the serial transmit framer: decoded write port in, serial line and status out.
interface serial_tx_framer_if;
  logic       SSER;
  logic       BA13;
  logic       BA12;
  logic [3:0] BA7_4;
  logic       BR_W;
  logic [7:0] BD;
  logic       SDWR;
  logic       BITSTB;
  logic       BUSY;
  logic       DONE;
  logic       OVR;

  modport master (
    output SSER, BA13, BA12, BA7_4, BR_W, BD,
    input  SDWR, BITSTB, BUSY, DONE, OVR
  );

  modport slave (
    input  SSER, BA13, BA12, BA7_4, BR_W, BD,
    output SDWR, BITSTB, BUSY, DONE, OVR
  );
endinterface

// File: rtl/serial_tx_framer.sv
// Bus-written byte framer: start bit, 8 data bits MSB first, odd parity, stop bit;
// each bit lasts DIV clocks. All outputs are registered.
module serial_tx_framer #(
  parameter int unsigned DIV = 4
) (
  input logic              clk,
  input logic              rst,
  serial_tx_framer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [7:0] LastCnt = 8'(DIV - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic       sdwr_q;
  logic       bitstb_q;
  logic       busy_q;
  logic       done_q;
  logic       ovr_q;

  logic wr_en;
  logic tx_wr;
  logic ctrl_wr;
  logic bit_end;

  assign wr_en   = !bus.SSER && !bus.BA13 && bus.BA12 && !bus.BR_W;
  assign tx_wr   = wr_en && (bus.BA7_4 == 4'h0);
  assign ctrl_wr = wr_en && (bus.BA7_4 == 4'h1);
  assign bit_end = (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      sdwr_q    <= 1'b1;
      bitstb_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      bitstb_q <= 1'b0;

      // Overrun set has priority over a CTRL clear.
      if (tx_wr && (state_q != StIdle)) begin
        ovr_q <= 1'b1;
      end else if (ctrl_wr && bus.BD[0]) begin
        ovr_q <= 1'b0;
      end

      if (state_q != StIdle) begin
        cnt_q    <= bit_end ? 8'h00 : cnt_q + 8'h01;
        bitstb_q <= bit_end && (state_q != StStop);
      end

      unique case (state_q)
        StIdle: begin
          if (tx_wr) begin
            state_q  <= StStart;
            cnt_q    <= '0;
            shreg_q  <= bus.BD;
            par_q    <= ~(^bus.BD);
            sdwr_q   <= 1'b0;
            bitstb_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
            sdwr_q    <= shreg_q[7];
            shreg_q   <= {shreg_q[6:0], 1'b0};
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
              sdwr_q  <= par_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              sdwr_q    <= shreg_q[7];
              shreg_q   <= {shreg_q[6:0], 1'b0};
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            sdwr_q  <= 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            state_q <= StIdle;
            sdwr_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          sdwr_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SDWR   = sdwr_q;
  assign bus.BITSTB = bitstb_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.OVR    = ovr_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed plus random-byte bench for serial_tx_framer; expected line levels come from the
// frame format (start, data MSB first, odd parity, stop) computed per byte.
module tb_serial_tx_framer;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_tx_framer_if bus_if ();

  serial_tx_framer #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus_if.SSER  = 1'b1;
    bus_if.BA13  = 1'b0;
    bus_if.BA12  = 1'b1;
    bus_if.BA7_4 = 4'h0;
    bus_if.BR_W  = 1'b1;
    bus_if.BD    = 8'h00;
  endtask

  // One bus cycle presented around a rising edge; returns 1 time unit after that edge.
  task automatic bus_cycle(input logic sser, input logic ba13, input logic ba12,
                           input logic [3:0] sel, input logic br_w, input logic [7:0] d);
    @(negedge clk);
    bus_if.SSER  = sser;
    bus_if.BA13  = ba13;
    bus_if.BA12  = ba12;
    bus_if.BA7_4 = sel;
    bus_if.BR_W  = br_w;
    bus_if.BD    = d;
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic write_tx(input logic [7:0] d);
    bus_cycle(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, d);
  endtask

  task automatic write_ctrl(input logic [7:0] d);
    bus_cycle(1'b0, 1'b0, 1'b1, 4'h1, 1'b0, d);
  endtask

  // Starts 1 unit after the accepting edge; ends 1 unit into the DONE cycle.
  task automatic check_frame(input logic [7:0] d);
    logic exp_bits [11];
    exp_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp_bits[k + 1] = d[7 - k];
    exp_bits[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    exp_bits[10] = 1'b1;
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("sdwr[%0d.%0d]", b, c), 8'(bus_if.SDWR), 8'(exp_bits[b]));
        chk("bitstb", 8'(bus_if.BITSTB), 8'(c == 0));
        chk("busy", 8'(bus_if.BUSY), 8'h01);
        chk("done_early", 8'(bus_if.DONE), 8'h00);
        @(posedge clk);
        #1;
      end
    end
    chk("done", 8'(bus_if.DONE), 8'h01);
    chk("busy_end", 8'(bus_if.BUSY), 8'h00);
    chk("sdwr_idle", 8'(bus_if.SDWR), 8'h01);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 8'(bus_if.BUSY), 8'h00);
    chk({tag, "_sdwr"}, 8'(bus_if.SDWR), 8'h01);
    @(posedge clk);
    #1;
    chk({tag, "_busy2"}, 8'(bus_if.BUSY), 8'h00);
    chk({tag, "_bitstb"}, 8'(bus_if.BITSTB), 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sdwr", 8'(bus_if.SDWR), 8'h01);
    chk("rst_bitstb", 8'(bus_if.BITSTB), 8'h00);
    chk("rst_busy", 8'(bus_if.BUSY), 8'h00);
    chk("rst_done", 8'(bus_if.DONE), 8'h00);
    chk("rst_ovr", 8'(bus_if.OVR), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, then parity corner bytes back-to-back from each DONE cycle.
    write_tx(8'hA5);
    check_frame(8'hA5);
    write_tx(8'h01);
    check_frame(8'h01);
    write_tx(8'h00);
    check_frame(8'h00);
    write_tx(8'h55);
    check_frame(8'h55);
    chk("ovr_clean", 8'(bus_if.OVR), 8'h00);

    // Overrun: second write mid-frame is dropped and flagged.
    @(negedge clk);
    write_tx(8'h3C);
    fork
      check_frame(8'h3C);
      begin
        repeat (10) @(posedge clk);
        write_tx(8'hFF);
      end
    join
    chk("ovr_set", 8'(bus_if.OVR), 8'h01);
    write_ctrl(8'hFE);
    chk("ovr_kept", 8'(bus_if.OVR), 8'h01);
    chk("ctrl_nostart", 8'(bus_if.BUSY), 8'h00);
    write_ctrl(8'h01);
    chk("ovr_clr", 8'(bus_if.OVR), 8'h00);

    // Ignored cycles.
    bus_cycle(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 8'hFF);
    check_quiet("read");
    bus_cycle(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'hFF);
    check_quiet("sser1");
    bus_cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'hFF);
    check_quiet("ba12_0");
    bus_cycle(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 8'hFF);
    check_quiet("ba13_1");

    // Abort during data bit 3.
    d = 8'hC3;
    write_tx(d);
    repeat (16) @(posedge clk);
    #1;
    chk("bit3_sdwr", 8'(bus_if.SDWR), 8'(d[4]));
    chk("bit3_stb", 8'(bus_if.BITSTB), 8'h01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_sdwr", 8'(bus_if.SDWR), 8'h01);
    chk("abort_busy", 8'(bus_if.BUSY), 8'h00);
    chk("abort_done", 8'(bus_if.DONE), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", 8'(bus_if.DONE), 8'h00);
    end
    write_tx(8'h96);
    check_frame(8'h96);

    // Reset beats a simultaneous write issued mid-frame.
    write_tx(8'h81);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst          = 1'b1;
    bus_if.SSER  = 1'b0;
    bus_if.BA13  = 1'b0;
    bus_if.BA12  = 1'b1;
    bus_if.BA7_4 = 4'h0;
    bus_if.BR_W  = 1'b0;
    bus_if.BD    = 8'hFF;
    @(posedge clk);
    #1;
    idle_bus();
    chk("rstwr_busy", 8'(bus_if.BUSY), 8'h00);
    chk("rstwr_ovr", 8'(bus_if.OVR), 8'h00);
    chk("rstwr_sdwr", 8'(bus_if.SDWR), 8'h01);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstwr_idle", 8'(bus_if.BUSY), 8'h00);

    // Random bytes, chained back-to-back.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      write_tx(d);
      check_frame(d);
    end
    chk("final_ovr", 8'(bus_if.OVR), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
